guard_reset_ctrl: RTL and testbench
===================================

Name: guard_reset_ctrl

Overview:
Downstream stage of the read/write guards. It consumes their latched reset requests and runs the recovery sequence: isolate the slave port, drain outstanding transactions (bounded by a timeout), pulse the slave reset, and wait for a software acknowledge. It then returns reset_clear to the guards. It sits between the guards' reset_req_o outputs and the slave-side isolation/reset logic.

Parameters:
MaxTxns, 8, maximum outstanding reads and maximum outstanding writes tracked; counter width is $clog2(MaxTxns+1).
DrainCycles, 256, maximum cycles spent in DRAIN before a forced reset; must be >= 1.
RstPulseCycles, 16, cycles slv_rst_no is held low; must be >= 1.
TmrWidth, $clog2(max(DrainCycles,RstPulseCycles)+1), shared timer width; derived, do not override.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_reset_req_i  in  1  latched reset request from the read guard
wr_reset_req_i  in  1  latched reset request from the write guard
sw_ack_i  in  1  one-cycle software acknowledge (register write strobe)
ar_hs_i  in  1  slave-side AR valid&ready
r_last_hs_i  in  1  slave-side R valid&ready&last
aw_hs_i  in  1  slave-side AW valid&ready
b_hs_i  in  1  slave-side B valid&ready
isolate_o  out  1  gate new AR/AW towards the slave
slv_rst_no  out  1  active-low reset to the slave
reset_clear_o  out  1  one-cycle pulse to the guards' reset_clear_i
busy_o  out  1  FSM not in IDLE
drain_timeout_o  out  1  last drain ended by timeout, not by empty
state_o  out  3  current state encoding, for status register

Behaviour:
- One clock domain: clk_i. Asynchronous active-low reset: rst_ni.
- Reset values: isolate_o=0, slv_rst_no=1, reset_clear_o=0, busy_o=0, drain_timeout_o=0, state_o=0. Counters and timer reset to 0.
- All outputs are registered and decoded from state (Moore).
- State encoding: IDLE=0, ISOLATE=1, DRAIN=2, RESET=3, WAIT_ACK=4, CLEAR=5. Values 6 and 7 are illegal and go to IDLE.
- IDLE: if rd_reset_req_i|wr_reset_req_i -> ISOLATE. The request sampled in cycle N gives isolate_o=1 in N+1.
- ISOLATE (1 cycle): clear drain_timeout_o; load timer=DrainCycles-1; -> DRAIN.
- DRAIN:
  - If rd_cnt==0 && wr_cnt==0 -> RESET.
  - Else if timer==0 -> set drain_timeout_o, -> RESET.
  - Else decrement the timer.
  - Empty takes priority over timeout in the same cycle.
  - On exit, load timer=RstPulseCycles-1.
- RESET: slv_rst_no=0. Counters are forced to 0 and handshake inputs ignored. When timer==0 -> WAIT_ACK, else decrement. Low time is exactly RstPulseCycles cycles.
- WAIT_ACK: isolate_o stays 1 and slv_rst_no=1. On sw_ack_i -> CLEAR. sw_ack_i in any other state is ignored.
- CLEAR (1 cycle): reset_clear_o=1; -> IDLE. The guards drop their requests on the same edge, so IDLE sees them low. If a guard re-requests, IDLE restarts the sequence.
- isolate_o=1 in ISOLATE, DRAIN, RESET, WAIT_ACK and CLEAR.
- busy_o=1 whenever state != IDLE.
- Outstanding counters rd_cnt and wr_cnt (rd shown; wr uses aw_hs_i/b_hs_i identically), updated in every state except RESET:
  - ar_hs_i only: +1, saturating at MaxTxns.
  - r_last_hs_i only: -1, saturating at 0.
  - Both in the same cycle: unchanged.
- Requests arriving while the FSM is not in IDLE are absorbed; no queuing.
- rst_ni mid-sequence returns everything to reset values immediately, including slv_rst_no=1.

Decomposition:
- Package guard_pkg holds:
  - the state enum guard_rst_state_e (3 bits, encodings above);
  - localparam helper for counter width.
- Sub-module txn_counter handles saturating up/down with synchronous clear. It is instantiated twice (rd, wr) with parameter MaxTxns.

Test Plan:
- Reset, then idle 10 cycles -> all outputs at reset values; state_o=0.
- 3 ar_hs_i pulses, no r_last; assert rd_reset_req_i at cycle 20 -> isolate_o=1 at 21, state_o=2 from 22. Then 3 r_last_hs_i at 30, 31, 32 -> slv_rst_no low from 33 for exactly 16 cycles; drain_timeout_o=0.
- DrainCycles=8; 1 aw_hs_i, never b_hs_i; wr_reset_req_i -> DRAIN lasts exactly 8 cycles; drain_timeout_o=1; RESET follows; wr_cnt=0 after RESET.
- In WAIT_ACK, hold 5 cycles, pulse sw_ack_i -> exactly one reset_clear_o pulse the next cycle, then busy_o=0. An sw_ack_i pulsed earlier during DRAIN -> no effect.
- ar_hs_i and r_last_hs_i high together with rd_cnt=2 -> rd_cnt stays 2. 9 ar_hs_i with MaxTxns=8 -> rd_cnt=8. r_last_hs_i at 0 -> stays 0.
- Deassert rst_ni during RESET state -> slv_rst_no=1 and isolate_o=0 asynchronously; state_o=0.

Source files
------------

// File: rtl/guard_pkg.sv
// Shared types for the guard reset controller: FSM state encoding and
// the width helper used by the outstanding-transaction counters.
package guard_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ISOLATE  = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_RESET    = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_CLEAR    = 3'd5
  } guard_rst_state_e;

  function automatic int cnt_width(input int max_txns);
    return $clog2(max_txns + 1);
  endfunction

endpackage

// File: rtl/txn_counter.sv
// Saturating up/down counter of outstanding transactions with a
// synchronous clear that overrides both handshakes.
module txn_counter
  import guard_pkg::*;
#(
  parameter int MaxTxns = 8,
  localparam int CntW   = cnt_width(MaxTxns)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clr,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [CntW-1:0] o_cnt
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

  logic [CntW-1:0] r_cnt;

  // Simultaneous issue and completion cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CntMax)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/guard_reset_ctrl.sv
// Recovery sequencer behind the read/write guards: isolate the slave,
// drain (bounded), pulse the slave reset, wait for software, clear guards.
module guard_reset_ctrl
  import guard_pkg::*;
#(
  parameter int MaxTxns        = 8,
  parameter int DrainCycles    = 256,
  parameter int RstPulseCycles = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rd_reset_req_i,
  input  logic       wr_reset_req_i,
  input  logic       sw_ack_i,
  input  logic       ar_hs_i,
  input  logic       r_last_hs_i,
  input  logic       aw_hs_i,
  input  logic       b_hs_i,
  output logic       isolate_o,
  output logic       slv_rst_no,
  output logic       reset_clear_o,
  output logic       busy_o,
  output logic       drain_timeout_o,
  output logic [2:0] state_o
);

  localparam int TmrMax   = (DrainCycles > RstPulseCycles) ? DrainCycles : RstPulseCycles;
  localparam int TmrWidth = $clog2(TmrMax + 1);
  localparam int CntW     = cnt_width(MaxTxns);

  localparam logic [TmrWidth-1:0] DrainLd = TmrWidth'(DrainCycles - 1);
  localparam logic [TmrWidth-1:0] RstLd   = TmrWidth'(RstPulseCycles - 1);

  guard_rst_state_e    r_state;
  logic [TmrWidth-1:0] r_timer;
  logic                r_isolate;
  logic                r_slv_rst_n;
  logic                r_reset_clear;
  logic                r_busy;
  logic                r_drain_to;

  logic [CntW-1:0] w_rd_cnt;
  logic [CntW-1:0] w_wr_cnt;
  logic            w_cnt_clr;
  logic            w_empty;

  // The slave is being reset, so anything it had in flight is gone.
  assign w_cnt_clr = (r_state == ST_RESET);
  assign w_empty   = (w_rd_cnt == '0) && (w_wr_cnt == '0);

  txn_counter #(.MaxTxns(MaxTxns)) u_rd_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_cnt_clr),
    .i_inc   (ar_hs_i),
    .i_dec   (r_last_hs_i),
    .o_cnt   (w_rd_cnt)
  );

  txn_counter #(.MaxTxns(MaxTxns)) u_wr_cnt (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_clr   (w_cnt_clr),
    .i_inc   (aw_hs_i),
    .i_dec   (b_hs_i),
    .o_cnt   (w_wr_cnt)
  );

  // Outputs are written alongside each transition so they track the new state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_isolate     <= 1'b0;
      r_slv_rst_n   <= 1'b1;
      r_reset_clear <= 1'b0;
      r_busy        <= 1'b0;
      r_drain_to    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (rd_reset_req_i || wr_reset_req_i) begin
            r_state    <= ST_ISOLATE;
            r_isolate  <= 1'b1;
            r_busy     <= 1'b1;
            r_drain_to <= 1'b0;
          end
        end
        ST_ISOLATE: begin
          r_state <= ST_DRAIN;
          r_timer <= DrainLd;
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state     <= ST_RESET;
            r_timer     <= RstLd;
            r_slv_rst_n <= 1'b0;
          end else if (r_timer == '0) begin
            r_state     <= ST_RESET;
            r_timer     <= RstLd;
            r_slv_rst_n <= 1'b0;
            r_drain_to  <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_RESET: begin
          if (r_timer == '0) begin
            r_state     <= ST_WAIT_ACK;
            r_slv_rst_n <= 1'b1;
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
        ST_WAIT_ACK: begin
          if (sw_ack_i) begin
            r_state       <= ST_CLEAR;
            r_reset_clear <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state       <= ST_IDLE;
          r_reset_clear <= 1'b0;
          r_isolate     <= 1'b0;
          r_busy        <= 1'b0;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_isolate     <= 1'b0;
          r_slv_rst_n   <= 1'b1;
          r_reset_clear <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign isolate_o       = r_isolate;
  assign slv_rst_no      = r_slv_rst_n;
  assign reset_clear_o   = r_reset_clear;
  assign busy_o          = r_busy;
  assign drain_timeout_o = r_drain_to;
  assign state_o         = r_state;

endmodule

// File: tb/tb_guard_reset_ctrl.sv
// Directed bench for guard_reset_ctrl (MaxTxns=8, DrainCycles=8, RstPulseCycles=16).
module tb_guard_reset_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rd_reset_req_i, wr_reset_req_i, sw_ack_i;
  logic       ar_hs_i, r_last_hs_i, aw_hs_i, b_hs_i;
  logic       isolate_o, slv_rst_no, reset_clear_o, busy_o, drain_timeout_o;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  guard_reset_ctrl #(
    .MaxTxns        (8),
    .DrainCycles    (8),
    .RstPulseCycles (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .rd_reset_req_i  (rd_reset_req_i),
    .wr_reset_req_i  (wr_reset_req_i),
    .sw_ack_i        (sw_ack_i),
    .ar_hs_i         (ar_hs_i),
    .r_last_hs_i     (r_last_hs_i),
    .aw_hs_i         (aw_hs_i),
    .b_hs_i          (b_hs_i),
    .isolate_o       (isolate_o),
    .slv_rst_no      (slv_rst_no),
    .reset_clear_o   (reset_clear_o),
    .busy_o          (busy_o),
    .drain_timeout_o (drain_timeout_o),
    .state_o         (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; rd_reset_req_i = 1'b0; wr_reset_req_i = 1'b0; sw_ack_i = 1'b0;
    ar_hs_i = 1'b0; r_last_hs_i = 1'b0; aw_hs_i = 1'b0; b_hs_i = 1'b0;
    repeat (3) step();
    rst_ni = 1'b1;
    repeat (10) step();
    n_tests++; if (isolate_o !== 1'b0) begin n_fail++; $display("FAIL rst_isolate got %b exp 0", isolate_o); end
    n_tests++; if (slv_rst_no !== 1'b1) begin n_fail++; $display("FAIL rst_slv_rst_n got %b exp 1", slv_rst_no); end
    n_tests++; if (reset_clear_o !== 1'b0) begin n_fail++; $display("FAIL rst_clear got %b exp 0", reset_clear_o); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    n_tests++; if (drain_timeout_o !== 1'b0) begin n_fail++; $display("FAIL rst_timeout got %b exp 0", drain_timeout_o); end
    n_tests++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state_o); end
  endtask

  task automatic test_counters();
    repeat (2) begin ar_hs_i = 1'b1; step(); end
    ar_hs_i = 1'b0; step();
    n_tests++; if (dut.w_rd_cnt !== 4'd2) begin n_fail++; $display("FAIL cnt_two got %0d exp 2", dut.w_rd_cnt); end
    ar_hs_i = 1'b1; r_last_hs_i = 1'b1; step();
    ar_hs_i = 1'b0; r_last_hs_i = 1'b0; step();
    n_tests++; if (dut.w_rd_cnt !== 4'd2) begin n_fail++; $display("FAIL cnt_both got %0d exp 2", dut.w_rd_cnt); end
    repeat (9) begin ar_hs_i = 1'b1; step(); end
    ar_hs_i = 1'b0; step();
    n_tests++; if (dut.w_rd_cnt !== 4'd8) begin n_fail++; $display("FAIL cnt_sat_hi got %0d exp 8", dut.w_rd_cnt); end
    repeat (9) begin r_last_hs_i = 1'b1; step(); end
    r_last_hs_i = 1'b0; step();
    n_tests++; if (dut.w_rd_cnt !== 4'd0) begin n_fail++; $display("FAIL cnt_sat_lo got %0d exp 0", dut.w_rd_cnt); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL cnt_idle_busy got %b exp 0", busy_o); end
  endtask

  // Count slv_rst_no low cycles, starting with the current (already low) sample.
  task automatic count_rst_low(output int low);
    low = 0;
    while (slv_rst_no === 1'b0 && low < 40) begin
      low++;
      step();
    end
  endtask

  // Sit in WAIT_ACK, acknowledge, and expect a single clear pulse.
  task automatic do_ack(input string tag);
    n_tests++; if (state_o !== 3'd4) begin n_fail++; $display("FAIL %s_wait_state got %0d exp 4", tag, state_o); end
    n_tests++; if (isolate_o !== 1'b1 || slv_rst_no !== 1'b1) begin
      n_fail++; $display("FAIL %s_wait_outs got iso=%b rstn=%b exp iso=1 rstn=1", tag, isolate_o, slv_rst_no);
    end
    repeat (5) step();
    n_tests++; if (state_o !== 3'd4 || reset_clear_o !== 1'b0) begin
      n_fail++; $display("FAIL %s_wait_hold got st=%0d clr=%b exp st=4 clr=0", tag, state_o, reset_clear_o);
    end
    sw_ack_i = 1'b1; step(); sw_ack_i = 1'b0;
    n_tests++; if (reset_clear_o !== 1'b1 || state_o !== 3'd5) begin
      n_fail++; $display("FAIL %s_clear got clr=%b st=%0d exp clr=1 st=5", tag, reset_clear_o, state_o);
    end
    rd_reset_req_i = 1'b0; wr_reset_req_i = 1'b0;
    step();
    n_tests++; if (reset_clear_o !== 1'b0 || busy_o !== 1'b0 || isolate_o !== 1'b0 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL %s_idle got clr=%b busy=%b iso=%b st=%0d exp 0 0 0 0",
                         tag, reset_clear_o, busy_o, isolate_o, state_o);
    end
    repeat (3) step();
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL %s_stay_idle got busy=%b exp 0", tag, busy_o); end
  endtask

  task automatic test_drain_empty();
    int low;
    repeat (3) begin ar_hs_i = 1'b1; step(); end
    ar_hs_i = 1'b0; step();
    rd_reset_req_i = 1'b1; step();
    n_tests++; if (isolate_o !== 1'b1 || state_o !== 3'd1) begin
      n_fail++; $display("FAIL de_isolate got iso=%b st=%0d exp iso=1 st=1", isolate_o, state_o);
    end
    step();
    n_tests++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL de_drain got %0d exp 2", state_o); end
    repeat (4) step();
    n_tests++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL de_drain_hold got %0d exp 2", state_o); end
    repeat (3) begin r_last_hs_i = 1'b1; step(); end
    r_last_hs_i = 1'b0;
    n_tests++; if (slv_rst_no !== 1'b1 || state_o !== 3'd2) begin
      n_fail++; $display("FAIL de_pre_reset got rstn=%b st=%0d exp rstn=1 st=2", slv_rst_no, state_o);
    end
    step();
    n_tests++; if (slv_rst_no !== 1'b0 || state_o !== 3'd3) begin
      n_fail++; $display("FAIL de_reset_entry got rstn=%b st=%0d exp rstn=0 st=3", slv_rst_no, state_o);
    end
    count_rst_low(low);
    n_tests++; if (low != 16) begin n_fail++; $display("FAIL de_pulse_len got %0d exp 16", low); end
    n_tests++; if (drain_timeout_o !== 1'b0) begin n_fail++; $display("FAIL de_timeout got %b exp 0", drain_timeout_o); end
    do_ack("de");
  endtask

  task automatic test_drain_timeout();
    int drain_len;
    int low;
    aw_hs_i = 1'b1; step(); aw_hs_i = 1'b0;
    wr_reset_req_i = 1'b1; step();
    n_tests++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL to_isolate got %0d exp 1", state_o); end
    step();
    drain_len = 0;
    while (state_o === 3'd2 && drain_len < 50) begin
      drain_len++;
      sw_ack_i = (drain_len == 3);
      step();
    end
    sw_ack_i = 1'b0;
    n_tests++; if (drain_len != 8) begin n_fail++; $display("FAIL to_drain_len got %0d exp 8", drain_len); end
    n_tests++; if (drain_timeout_o !== 1'b1 || state_o !== 3'd3 || slv_rst_no !== 1'b0) begin
      n_fail++; $display("FAIL to_reset got to=%b st=%0d rstn=%b exp to=1 st=3 rstn=0", drain_timeout_o, state_o, slv_rst_no);
    end
    step();
    n_tests++; if (dut.w_wr_cnt !== 4'd0) begin n_fail++; $display("FAIL to_wr_cnt_clr got %0d exp 0", dut.w_wr_cnt); end
    count_rst_low(low);
    n_tests++; if (low != 15) begin n_fail++; $display("FAIL to_pulse_len got %0d exp 15", low); end
    do_ack("to");
    n_tests++; if (drain_timeout_o !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b exp 1", drain_timeout_o); end
  endtask

  task automatic test_async_reset();
    int waited;
    rd_reset_req_i = 1'b1;
    waited = 0;
    while (state_o !== 3'd3 && waited < 50) begin waited++; step(); end
    n_tests++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL ar_reach_reset got %0d exp 3", state_o); end
    step();
    #2 rst_ni = 1'b0;
    #1;
    n_tests++; if (slv_rst_no !== 1'b1 || isolate_o !== 1'b0 || state_o !== 3'd0 || busy_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_async got rstn=%b iso=%b st=%0d busy=%b exp 1 0 0 0", slv_rst_no, isolate_o, state_o, busy_o);
    end
    rd_reset_req_i = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (2) step();
    n_tests++; if (state_o !== 3'd0 || drain_timeout_o !== 1'b0) begin
      n_fail++; $display("FAIL ar_after got st=%0d to=%b exp 0 0", state_o, drain_timeout_o);
    end
  endtask

  initial begin
    test_reset();
    test_counters();
    test_drain_empty();
    test_drain_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
